// File: rtl/axi_lite_slave_regs_if.sv
// AXI4-Lite slave-side bus bundle for the register block.
// Clock and reset stay as plain ports on the modules that use this.
interface axi_lite_slave_regs_if #(
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_S_AXI_DATA_WIDTH = 32
);
  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR;
  logic [2:0]                      S_AXI_AWPROT;
  logic                            S_AXI_AWVALID;
  logic                            S_AXI_AWREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB;
  logic                            S_AXI_WVALID;
  logic                            S_AXI_WREADY;
  logic [1:0]                      S_AXI_BRESP;
  logic                            S_AXI_BVALID;
  logic                            S_AXI_BREADY;
  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR;
  logic [2:0]                      S_AXI_ARPROT;
  logic                            S_AXI_ARVALID;
  logic                            S_AXI_ARREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA;
  logic [1:0]                      S_AXI_RRESP;
  logic                            S_AXI_RVALID;
  logic                            S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );
endinterface

// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite register file: reg 0 is a read-only ID, regs 1..N-1 are byte-strobed RW.
// AW and W are captured independently; the write commits when the later of the two lands.
module axi_lite_reg_slot #(
  parameter int DW = 32
) (
  input  logic            gclk,
  input  logic            grst_n,
  input  logic            we,
  input  logic [DW/8-1:0] strb,
  input  logic [DW-1:0]   wdata,
  output logic [DW-1:0]   q
);
  always_ff @(posedge gclk) begin
    if (!grst_n) q <= '0;
    else if (we) begin
      for (int b = 0; b < DW/8; b++)
        if (strb[b]) q[8*b +: 8] <= wdata[8*b +: 8];
    end
  end
endmodule

module axi_lite_slave_regs #(
  parameter int          C_S_AXI_ADDR_WIDTH = 32,
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_NUM_REGS         = 16,
  parameter logic [31:0] C_ID               = 32'hA11E0001
) (
  input  logic                                   S_AXI_ACLK,
  input  logic                                   S_AXI_ARESETN,
  axi_lite_slave_regs_if.slave                   s_axi,
  output logic [C_S_AXI_DATA_WIDTH*C_NUM_REGS-1:0] REGS_OUT
);
  localparam int IDX_W = $clog2(C_NUM_REGS);
  localparam int DW    = C_S_AXI_DATA_WIDTH;
  localparam int SW    = DW/8;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef logic [C_S_AXI_ADDR_WIDTH-1:0] addr_t;
  typedef struct packed {
    logic             in_range;
    logic [IDX_W-1:0] idx;
  } dec_t;

  // Any set bit above the index field makes the access out of range.
  function automatic dec_t decode(input addr_t a);
    dec_t d;
    d.idx      = a[IDX_W+1:2];
    d.in_range = (a >> (IDX_W+2)) == '0;
    return d;
  endfunction

  logic                           aw_full, w_full, bvalid, rvalid;
  addr_t                          aw_addr_q;
  logic [DW-1:0]                  w_data_q, rdata;
  logic [SW-1:0]                  w_strb_q;
  logic [1:0]                     bresp, rresp;
  logic                           awready, wready, arready;
  logic                           aw_hs, w_hs, ar_hs, commit, wr_ok;
  addr_t                          wr_addr;
  logic [DW-1:0]                  wr_data;
  logic [SW-1:0]                  wr_strb;
  dec_t                           wr_dec, rd_dec;
  logic [C_NUM_REGS-1:0][DW-1:0]  regs;
  logic                           unused_prot;

  assign unused_prot = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT};

  assign awready = !aw_full && !bvalid;
  assign wready  = !w_full  && !bvalid;
  assign arready = !rvalid;

  assign s_axi.S_AXI_AWREADY = awready;
  assign s_axi.S_AXI_WREADY  = wready;
  assign s_axi.S_AXI_BVALID  = bvalid;
  assign s_axi.S_AXI_BRESP   = bresp;
  assign s_axi.S_AXI_ARREADY = arready;
  assign s_axi.S_AXI_RVALID  = rvalid;
  assign s_axi.S_AXI_RDATA   = rdata;
  assign s_axi.S_AXI_RRESP   = rresp;

  assign aw_hs = s_axi.S_AXI_AWVALID && awready;
  assign w_hs  = s_axi.S_AXI_WVALID  && wready;
  assign ar_hs = s_axi.S_AXI_ARVALID && arready;

  // Bypass the holding register when its half arrives on the commit edge itself.
  assign wr_addr = aw_full ? aw_addr_q : s_axi.S_AXI_AWADDR;
  assign wr_data = w_full  ? w_data_q  : s_axi.S_AXI_WDATA;
  assign wr_strb = w_full  ? w_strb_q  : s_axi.S_AXI_WSTRB;
  assign commit  = (aw_full || aw_hs) && (w_full || w_hs);
  assign wr_dec  = decode(wr_addr);
  assign wr_ok   = wr_dec.in_range && (wr_dec.idx != '0);

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      aw_full   <= 1'b0;
      w_full    <= 1'b0;
      bvalid    <= 1'b0;
      bresp     <= RESP_OKAY;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else if (commit) begin
      aw_full <= 1'b0;
      w_full  <= 1'b0;
      bvalid  <= 1'b1;
      bresp   <= wr_ok ? RESP_OKAY : RESP_SLVERR;
    end else begin
      if (aw_hs) begin
        aw_full   <= 1'b1;
        aw_addr_q <= s_axi.S_AXI_AWADDR;
      end
      if (w_hs) begin
        w_full   <= 1'b1;
        w_data_q <= s_axi.S_AXI_WDATA;
        w_strb_q <= s_axi.S_AXI_WSTRB;
      end
      if (bvalid && s_axi.S_AXI_BREADY) bvalid <= 1'b0;
    end
  end

  assign regs[0] = C_ID;

  for (genvar i = 1; i < C_NUM_REGS; i++) begin : g_reg
    axi_lite_reg_slot #(.DW(DW)) u_slot (
      .gclk   (S_AXI_ACLK),
      .grst_n (S_AXI_ARESETN),
      .we     (commit && wr_ok && (wr_dec.idx == IDX_W'(i))),
      .strb   (wr_strb),
      .wdata  (wr_data),
      .q      (regs[i])
    );
  end

  // Read samples regs before any same-edge commit lands, so it sees the old value.
  assign rd_dec = decode(s_axi.S_AXI_ARADDR);

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      rvalid <= 1'b0;
      rdata  <= '0;
      rresp  <= RESP_OKAY;
    end else if (ar_hs) begin
      rvalid <= 1'b1;
      if (rd_dec.in_range) begin
        rdata <= regs[rd_dec.idx];
        rresp <= RESP_OKAY;
      end else begin
        rdata <= '0;
        rresp <= RESP_SLVERR;
      end
    end else if (rvalid && s_axi.S_AXI_RREADY) begin
      rvalid <= 1'b0;
    end
  end

  assign REGS_OUT = regs;
endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// Directed bench for axi_lite_slave_regs: B/R scoreboards plus a register model.
module tb_axi_lite_slave_regs;
  localparam int          AW  = 32;
  localparam int          N   = 16;
  localparam logic [31:0] CID = 32'hA11E0001;

  logic           S_AXI_ACLK = 1'b0;
  logic           S_AXI_ARESETN = 1'b0;
  logic [32*N-1:0] REGS_OUT;

  axi_lite_slave_regs_if #(.C_S_AXI_ADDR_WIDTH(AW), .C_S_AXI_DATA_WIDTH(32)) bus ();

  axi_lite_slave_regs #(
    .C_S_AXI_ADDR_WIDTH (AW),
    .C_S_AXI_DATA_WIDTH (32),
    .C_NUM_REGS         (N),
    .C_ID               (CID)
  ) dut (
    .S_AXI_ACLK    (S_AXI_ACLK),
    .S_AXI_ARESETN (S_AXI_ARESETN),
    .s_axi         (bus.slave),
    .REGS_OUT      (REGS_OUT)
  );

  always #5 S_AXI_ACLK = ~S_AXI_ACLK;

  int          n_vec = 0;
  int          n_err = 0;
  logic [1:0]  q_b[$];
  logic [33:0] q_r[$];
  logic [31:0] model[N];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_regs(input string tag);
    logic [32*N-1:0] exp;
    for (int i = 0; i < N; i++) exp[32*i +: 32] = model[i];
    n_vec++;
    assert (REGS_OUT === exp) else begin
      n_err++;
      $error("FAIL %s: REGS_OUT got %h expected %h", tag, REGS_OUT, exp);
    end
  endtask

  function automatic logic [31:0] apply(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Update the model for a write and return the response the DUT must give.
  task automatic upd_model(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    int idx;
    idx = int'(a[5:2]);
    if (a[31:6] != '0 || idx == 0) resp = 2'b10;
    else begin
      resp = 2'b00;
      model[idx] = apply(model[idx], d, s);
    end
  endtask

  function automatic logic [33:0] rd_exp(input logic [31:0] a);
    if (a[31:6] != '0) return {2'b10, 32'h0};
    return {2'b00, model[int'(a[5:2])]};
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_awready"}, 64'(bus.S_AXI_AWREADY), 64'd1);
    chk({tag, "_wready"},  64'(bus.S_AXI_WREADY),  64'd1);
    chk({tag, "_arready"}, 64'(bus.S_AXI_ARREADY), 64'd1);
    chk({tag, "_bvalid"},  64'(bus.S_AXI_BVALID),  64'd0);
    chk({tag, "_rvalid"},  64'(bus.S_AXI_RVALID),  64'd0);
    chk({tag, "_bresp"},   64'(bus.S_AXI_BRESP),   64'd0);
    chk({tag, "_rresp"},   64'(bus.S_AXI_RRESP),   64'd0);
    chk({tag, "_rdata"},   64'(bus.S_AXI_RDATA),   64'd0);
    chk_regs({tag, "_regs"});
  endtask

  task automatic do_reset(input int cyc);
    @(negedge S_AXI_ACLK);
    S_AXI_ARESETN = 1'b0;
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_BREADY = 1'b0;  bus.S_AXI_RREADY = 1'b0;
    repeat (cyc) @(negedge S_AXI_ACLK);
    S_AXI_ARESETN = 1'b1;
    for (int i = 0; i < N; i++) model[i] = '0;
    model[0] = CID;
    q_b.delete();
    q_r.delete();
  endtask

  // Pop-and-compare the next B response; bounded wait, then one-cycle BREADY.
  task automatic wait_b(input string tag);
    bit got = 0;
    for (int c = 0; c < 16 && !got; c++) begin
      if (bus.S_AXI_BVALID) begin
        got = 1;
        if (q_b.size() == 0) chk({tag, "_b_sb_empty"}, 64'd1, 64'd0);
        else chk({tag, "_bresp"}, 64'(bus.S_AXI_BRESP), 64'(q_b.pop_front()));
        bus.S_AXI_BREADY = 1'b1;
      end
      @(negedge S_AXI_ACLK);
      bus.S_AXI_BREADY = 1'b0;
    end
    if (!got) chk({tag, "_b_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic wait_r(input string tag);
    bit got = 0;
    for (int c = 0; c < 16 && !got; c++) begin
      if (bus.S_AXI_RVALID) begin
        got = 1;
        if (q_r.size() == 0) chk({tag, "_r_sb_empty"}, 64'd1, 64'd0);
        else chk({tag, "_rresp_rdata"}, 64'({bus.S_AXI_RRESP, bus.S_AXI_RDATA}), 64'(q_r.pop_front()));
        bus.S_AXI_RREADY = 1'b1;
      end
      @(negedge S_AXI_ACLK);
      bus.S_AXI_RREADY = 1'b0;
    end
    if (!got) chk({tag, "_r_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic wr(input string tag, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [1:0] resp;
    bit awd = 0, wd = 0;
    upd_model(a, d, s, resp);
    q_b.push_back(resp);
    bus.S_AXI_AWADDR = a; bus.S_AXI_WDATA = d; bus.S_AXI_WSTRB = s;
    bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1;
    for (int c = 0; c < 16 && !(awd && wd); c++) begin
      if (bus.S_AXI_AWVALID && bus.S_AXI_AWREADY) awd = 1;
      if (bus.S_AXI_WVALID && bus.S_AXI_WREADY) wd = 1;
      @(negedge S_AXI_ACLK);
      if (awd) bus.S_AXI_AWVALID = 1'b0;
      if (wd)  bus.S_AXI_WVALID  = 1'b0;
    end
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
    chk({tag, "_accept"}, 64'({awd, wd}), 64'd3);
    chk({tag, "_b_lat"}, 64'(bus.S_AXI_BVALID), 64'd1);
    wait_b(tag);
    chk_regs({tag, "_regs"});
  endtask

  task automatic rd(input string tag, input logic [31:0] a);
    bit ard = 0;
    q_r.push_back(rd_exp(a));
    bus.S_AXI_ARADDR = a; bus.S_AXI_ARVALID = 1'b1;
    for (int c = 0; c < 16 && !ard; c++) begin
      if (bus.S_AXI_ARREADY) ard = 1;
      @(negedge S_AXI_ACLK);
    end
    bus.S_AXI_ARVALID = 1'b0;
    chk({tag, "_ar_accept"}, 64'(ard), 64'd1);
    chk({tag, "_r_lat"}, 64'(bus.S_AXI_RVALID), 64'd1);
    wait_r(tag);
  endtask

  initial begin
    logic [1:0]  resp;
    logic [31:0] a, d;
    logic [3:0]  s;
    bus.S_AXI_AWADDR = '0; bus.S_AXI_AWPROT = '0; bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA = '0;  bus.S_AXI_WSTRB = '0;  bus.S_AXI_WVALID = 1'b0;
    bus.S_AXI_BREADY = 1'b0;
    bus.S_AXI_ARADDR = '0; bus.S_AXI_ARPROT = '0; bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY = 1'b0;

    do_reset(3);
    chk_idle("reset");

    // Simultaneous AW+W, then read back
    wr("w04", 32'h04, 32'hDEADBEEF, 4'hF);
    rd("r04", 32'h04);

    // W first, AW three cycles later, partial strobes
    upd_model(32'h08, 32'h11223344, 4'b0101, resp);
    q_b.push_back(resp);
    bus.S_AXI_WDATA = 32'h11223344; bus.S_AXI_WSTRB = 4'b0101; bus.S_AXI_WVALID = 1'b1;
    @(negedge S_AXI_ACLK);
    bus.S_AXI_WVALID = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      chk($sformatf("wfirst_wready_c%0d", c), 64'(bus.S_AXI_WREADY), 64'd0);
      chk($sformatf("wfirst_bvalid_c%0d", c), 64'(bus.S_AXI_BVALID), 64'd0);
      if (c == 3) begin bus.S_AXI_AWADDR = 32'h08; bus.S_AXI_AWVALID = 1'b1; end
      else @(negedge S_AXI_ACLK);
    end
    @(negedge S_AXI_ACLK);
    bus.S_AXI_AWVALID = 1'b0;
    chk("wfirst_bvalid_c4", 64'(bus.S_AXI_BVALID), 64'd1);
    chk("wfirst_reg2", 64'(REGS_OUT[64 +: 32]), 64'h00220044);
    wait_b("wfirst");
    chk_regs("wfirst_regs");

    // B stalled for 5 cycles with a second write waiting
    upd_model(32'h0C, 32'hA5A5A5A5, 4'hF, resp);
    q_b.push_back(resp);
    bus.S_AXI_AWADDR = 32'h0C; bus.S_AXI_WDATA = 32'hA5A5A5A5; bus.S_AXI_WSTRB = 4'hF;
    bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1;
    @(negedge S_AXI_ACLK);
    bus.S_AXI_AWADDR = 32'h10; bus.S_AXI_WDATA = 32'h0BADF00D;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bstall_bvalid_c%0d", c), 64'(bus.S_AXI_BVALID), 64'd1);
      chk($sformatf("bstall_bresp_c%0d", c), 64'(bus.S_AXI_BRESP), 64'd0);
      chk($sformatf("bstall_awready_c%0d", c), 64'(bus.S_AXI_AWREADY), 64'd0);
      chk($sformatf("bstall_wready_c%0d", c), 64'(bus.S_AXI_WREADY), 64'd0);
      @(negedge S_AXI_ACLK);
    end
    chk_regs("bstall_reg4_untouched");
    wait_b("bstall_first");
    chk("bstall_awready_after", 64'(bus.S_AXI_AWREADY), 64'd1);
    chk("bstall_wready_after", 64'(bus.S_AXI_WREADY), 64'd1);
    upd_model(32'h10, 32'h0BADF00D, 4'hF, resp);
    q_b.push_back(resp);
    @(negedge S_AXI_ACLK);
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
    chk("bstall_second_b_lat", 64'(bus.S_AXI_BVALID), 64'd1);
    wait_b("bstall_second");
    chk_regs("bstall_regs");

    // Error decode: reg 0 and above the index field
    wr("w00", 32'h00, 32'hFFFFFFFF, 4'hF);
    wr("w100", 32'h100, 32'h12345678, 4'hF);
    rd("r00", 32'h00);
    rd("r100", 32'h100);
    rd("r03_lowbits", 32'h07);

    // AR on the same edge as a commit to the same register
    wr("w04_5", 32'h04, 32'd5, 4'hF);
    q_r.push_back(rd_exp(32'h04));
    upd_model(32'h04, 32'd9, 4'hF, resp);
    q_b.push_back(resp);
    bus.S_AXI_AWADDR = 32'h04; bus.S_AXI_WDATA = 32'd9; bus.S_AXI_WSTRB = 4'hF;
    bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1;
    bus.S_AXI_ARADDR = 32'h04; bus.S_AXI_ARVALID = 1'b1;
    @(negedge S_AXI_ACLK);
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_ARVALID = 1'b0;
    chk("same_edge_b_lat", 64'(bus.S_AXI_BVALID), 64'd1);
    wait_b("same_edge");
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("rstall_rvalid_c%0d", c), 64'(bus.S_AXI_RVALID), 64'd1);
      chk($sformatf("rstall_rdata_c%0d", c), 64'(bus.S_AXI_RDATA), 64'd5);
      chk($sformatf("rstall_arready_c%0d", c), 64'(bus.S_AXI_ARREADY), 64'd0);
      @(negedge S_AXI_ACLK);
    end
    wait_r("same_edge");
    chk("rstall_rvalid_drop", 64'(bus.S_AXI_RVALID), 64'd0);
    chk("rstall_arready_back", 64'(bus.S_AXI_ARREADY), 64'd1);
    rd("r04_9", 32'h04);

    // All-zero strobe is an OKAY no-op
    wr("wstrb0", 32'h14, 32'hFFFFFFFF, 4'h0);
    rd("rstrb0", 32'h14);

    // A few mixed writes and readbacks
    for (int k = 0; k < 8; k++) begin
      a = {26'h0, 4'($urandom_range(0, N-1)), 2'b00};
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      wr($sformatf("rand_w%0d", k), a, d, s);
      rd($sformatf("rand_r%0d", k), a);
    end

    // Reset with only AW captured: the stale AW must not pair with a later W
    bus.S_AXI_AWADDR = 32'h0C; bus.S_AXI_AWVALID = 1'b1;
    @(negedge S_AXI_ACLK);
    bus.S_AXI_AWVALID = 1'b0;
    chk("midrst_aw_held", 64'(bus.S_AXI_AWREADY), 64'd0);
    do_reset(2);
    chk_idle("midrst");
    bus.S_AXI_WDATA = 32'h00000077; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
    @(negedge S_AXI_ACLK);
    bus.S_AXI_WVALID = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("midrst_no_b_c%0d", c), 64'(bus.S_AXI_BVALID), 64'd0);
      @(negedge S_AXI_ACLK);
    end
    chk("midrst_wready", 64'(bus.S_AXI_WREADY), 64'd0);
    chk_regs("midrst_regs_untouched");
    upd_model(32'h10, 32'h00000077, 4'hF, resp);
    q_b.push_back(resp);
    bus.S_AXI_AWADDR = 32'h10; bus.S_AXI_AWVALID = 1'b1;
    @(negedge S_AXI_ACLK);
    bus.S_AXI_AWVALID = 1'b0;
    chk("midrst_b_lat", 64'(bus.S_AXI_BVALID), 64'd1);
    wait_b("midrst_complete");
    chk_regs("midrst_final_regs");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/axi_lite_slave_regs.md
AXI_LITE_SLAVE_REGS -- requirements
Module: axi_lite_slave_regs

Interface
REQ-001 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 32, AXI address width.
REQ-002 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, data width (only 32 supported).
REQ-003 SHALL have parameter C_NUM_REGS, default 16, number of 32-bit registers (power of 2).
REQ-004 SHALL have parameter C_ID, default 32'hA11E0001, constant read value of register 0.
REQ-005 SHALL have ports:
 S_AXI_ACLK  in  1  clock, all logic on rising edge
 S_AXI_ARESETN  in  1  reset, synchronous, active-low
 S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address
 S_AXI_AWPROT  in  3  ignored
 S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write address handshake
 S_AXI_WDATA  in  32  write data
 S_AXI_WSTRB  in  4  byte enables
 S_AXI_WVALID / S_AXI_WREADY  in / out  1  write data handshake
 S_AXI_BRESP  out  2  write response
 S_AXI_BVALID / S_AXI_BREADY  out / in  1  write response handshake
 S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address
 S_AXI_ARPROT  in  3  ignored
 S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read address handshake
 S_AXI_RDATA  out  32  read data
 S_AXI_RRESP  out  2  read response
 S_AXI_RVALID / S_AXI_RREADY  out / in  1  read data handshake
 REGS_OUT  out  32*C_NUM_REGS  flat register contents, reg i at bits [32i+31:32i]
REQ-006 SHALL use one clock; reset is synchronous and active-low.

Function
REQ-007 Decode: index = addr[log2(C_NUM_REGS)+1:2]; addr[1:0] ignored; any nonzero bit above the index field = out of range.
REQ-008 AWREADY SHALL be 1 iff no AW captured and BVALID=0; WREADY SHALL be 1 iff no W captured and BVALID=0.
REQ-009 AW and W SHALL be accepted independently, either order or same cycle; each captured into a holding register at its handshake edge.
REQ-010 Commit on the edge completing the later of AW/W (or both same edge): apply WSTRB byte-wise to target register; BVALID=1 from the next cycle; holding flags cleared.
REQ-011 BRESP SHALL be 2'b00 OKAY for in-range writes to index 1..C_NUM_REGS-1; 2'b10 SLVERR for out-of-range or index 0, with no register change.
REQ-012 BVALID and BRESP SHALL hold stable until BVALID&&BREADY, then BVALID=0 next cycle; AWREADY/WREADY re-assert that cycle.
REQ-013 WSTRB=4'b0000 in-range SHALL return OKAY and change nothing.
REQ-014 ARREADY SHALL be 1 iff RVALID=0.
REQ-015 On ARVALID&&ARREADY edge: RDATA registered from addressed register (C_ID for index 0), RVALID=1 next cycle, RRESP=OKAY; out of range: RDATA=0, RRESP=2'b10.
REQ-016 RVALID, RDATA, RRESP SHALL hold stable until RVALID&&RREADY; RVALID=0 next cycle; read throughput max one per two cycles.
REQ-017 Read and write channels SHALL operate concurrently; AR handshake on the same edge as a commit to the same register SHALL return the pre-commit value.
REQ-018 REGS_OUT SHALL reflect register state with no extra latency after the commit edge; slice 0 = C_ID.
REQ-019 VALID outputs SHALL never depend combinationally on READY inputs.

Reset
REQ-020 While S_AXI_ARESETN=0 at a rising edge: registers 1..N-1 = 0, holding flags cleared, BVALID=RVALID=0, BRESP=RRESP=0, RDATA=0; AWREADY=WREADY=ARREADY=1 from the first cycle after reset release.
REQ-021 Reset mid-transaction SHALL discard captured AW/W and pending B/R without committing.

Verification
REQ-022 AW+W same cycle, addr 0x04, data 0xDEADBEEF, WSTRB 4'hF -> BVALID next cycle, BRESP 00; read 0x04 -> RDATA 0xDEADBEEF, RRESP 00.
REQ-023 W at cycle 0, AW addr 0x08 at cycle 3, WSTRB 4'b0101, data 0x11223344 on reg=0 -> WREADY low cycles 1-3, reg2 = 0x00220044, BVALID cycle 4.
REQ-024 BREADY held 0 for 5 cycles -> BVALID/BRESP stable, AWREADY=WREADY=0 throughout; second write accepted only after B handshake.
REQ-025 Write 0x00 and write/read 0x100 -> BRESP 10, REGS_OUT unchanged; read 0x00 -> C_ID, RRESP 00; read 0x100 -> RDATA 0, RRESP 10.
REQ-026 Reg1=5, commit 9 to reg1 on same edge as AR for 0x04 -> RDATA 5; next read -> 9; RREADY stalled 3 cycles -> RDATA stable, ARREADY 0.
REQ-027 Reset asserted after AW captured, before W -> post-reset W alone yields no BVALID; all outputs at reset values.
